// File: rtl/led_slot_arbiter.sv
// Round-robin owner of a shared LED bank: one pattern source at a time, each for a
// fixed tick-based slot (or less on early release), with a one-cycle blank gap between owners.
module led_slot_arbiter #(
  parameter int NREQ       = 3,
  parameter int LEDS       = 5,
  parameter int LOG2TICK   = 22,
  parameter int SLOT_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LEDS-1:0] pat,
  output logic [NREQ-1:0]      gnt,
  output logic [LEDS-1:0]      led,
  output logic                 busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam int            IW        = $clog2(NREQ);
  localparam logic [7:0]    LAST_TICK = 8'(SLOT_TICKS - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  logic [0:0]          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [LEDS-1:0]     led_q, led_d;
  logic [IW-1:0]       last_q, last_d;
  logic [LOG2TICK-1:0] presc_q, presc_d;
  logic [7:0]          slot_q, slot_d;

  logic [LEDS-1:0] pat_arr [NREQ];
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic            tick;
  logic            slot_end;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pat
      assign pat_arr[gi] = pat[gi*LEDS +: LEDS];
    end
  endgenerate

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = IW'((int'(last_q) + k) % NREQ);
      if (req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign tick     = (presc_q == {LOG2TICK{1'b1}});
  assign slot_end = !req[last_q] || (tick && (slot_q == LAST_TICK));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    last_d  = last_q;
    presc_d = presc_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE: begin
        gnt_d   = '0;
        led_d   = '0;
        presc_d = '0;
        slot_d  = '0;
        if (win_valid) begin
          state_d = S_GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          last_d  = win_idx;
        end
      end
      S_GRANT: begin
        if (slot_end) begin
          // Blank gap: the bank goes dark for one cycle before the next owner.
          state_d = S_IDLE;
          gnt_d   = '0;
          led_d   = '0;
          presc_d = '0;
          slot_d  = '0;
        end else begin
          led_d   = pat_arr[last_q];
          presc_d = presc_q + 1'b1;
          if (tick) begin
            slot_d = slot_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      led_q   <= '0;
      last_q  <= LAST_INIT;
      presc_q <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      last_q  <= last_d;
      presc_q <= presc_d;
      slot_q  <= slot_d;
    end
  end

  assign gnt  = gnt_q;
  assign led  = led_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_led_slot_arbiter.sv
// Directed and random stimulus for led_slot_arbiter, checked every cycle against
// a slot-length/ownership reference model.
module tb_led_slot_arbiter;

  localparam int NREQ       = 3;
  localparam int LEDS       = 5;
  localparam int LOG2TICK   = 2;
  localparam int SLOT_TICKS = 3;
  localparam int SLOT_LEN   = SLOT_TICKS * (1 << LOG2TICK);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*LEDS-1:0] pat = '0;
  logic [NREQ-1:0]      gnt;
  logic [LEDS-1:0]      led;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bank and for how many cycles it has held it.
  int          m_owner = -1;
  int          m_age   = 0;
  int          m_last  = NREQ - 1;
  logic [LEDS-1:0] m_led = '0;

  led_slot_arbiter #(
    .NREQ(NREQ), .LEDS(LEDS), .LOG2TICK(LOG2TICK), .SLOT_TICKS(SLOT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pat(pat),
    .gnt(gnt), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = NREQ - 1;
    m_led   = '0;
  endtask

  task automatic model_edge();
    if (m_owner < 0) begin
      m_led = '0;
      if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_owner < 0 && req[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
        end
        m_last = m_owner;
        m_age  = 1;
      end
    end else if (!req[m_owner] || m_age == SLOT_LEN) begin
      m_owner = -1;
      m_led   = '0;
    end else begin
      m_led = pat[m_owner*LEDS +: LEDS];
      m_age++;
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] eg;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    eg = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("led", 32'(led), 32'(m_led));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic wait_model(input int own, input int age, input string tag);
    int n = 0;
    while (!(m_owner == own && m_age == age) && n < 300) begin
      step();
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    int run;
    int ng;
    int exp_seq [4];
    exp_seq = '{2, 4, 1, 2};

    // Reset held, then released with no requests.
    repeat (2) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // A one-cycle req pulse inside IDLE that misses the sampling edge is forgotten.
    #2 req = 3'b001;
    #3 req = 3'b000;
    step();
    chk("glitch_gnt", 32'(gnt), 32'd0);

    // Single source: slot length, blank gap, re-grant.
    pat[0 +: LEDS] = 5'b10101;
    req = 3'b001;
    run = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt == 3'b001) run++;
      else if (run > 0) break;
    end
    chk("slot_len", 32'(run), 32'(SLOT_LEN));
    chk("gap_led", 32'(led), 32'd0);
    step();
    chk("regrant", 32'(gnt), 32'b001);

    // Round robin with everyone requesting.
    pat = {5'b00100, 5'b00010, 5'b00001};
    req = 3'b111;
    ng = 0;
    for (int i = 0; i < 120 && ng < 4; i++) begin
      logic [NREQ-1:0] prev;
      prev = gnt;
      step();
      if (prev == '0 && gnt != '0) begin
        chk("rr_order", 32'(gnt), 32'(exp_seq[ng]));
        ng++;
      end
    end
    chk("rr_count", 32'(ng), 32'd4);

    // Early release of source 1 at its fifth granted cycle.
    wait_model(1, 5, "wait_src1");
    req = 3'b101;
    step();
    chk("early_gnt", 32'(gnt), 32'd0);
    step();
    chk("after_early", 32'(gnt), 32'b100);

    // Live pattern change during source 2's slot.
    wait_model(2, 3, "wait_src2");
    pat[2*LEDS +: LEDS] = 5'b11111;
    step();
    step();
    chk("live_hi", 32'(led), 32'b11111);
    pat[2*LEDS +: LEDS] = 5'b00000;
    step();
    chk("live_lo", 32'(led), 32'b00000);

    // After source 2's slot with req=101, source 0 is next.
    run = 0;
    while (gnt != 3'b000 && run < 40) begin step(); run++; end
    step();
    chk("rotate", 32'(gnt), 32'b001);

    // Asynchronous reset mid-slot.
    repeat (4) step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) step();
    req = 3'b000;
    rst_n = 1'b1;
    repeat (3) step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req = req ^ NREQ'(1 << $urandom_range(0, NREQ - 1));
      if ($urandom_range(0, 3) == 0) pat = (NREQ*LEDS)'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_slot_arbiter.md
Name: led_slot_arbiter

Overview:
- Shares the LED bank between NREQ pattern sources, e.g. counters, status indicators and debug sources.
- Grants one source at a time using round-robin arbitration.
- Each grant lasts a fixed time slot built from a prescaled tick. The slot ends early if the granted source drops its request.
- Sits between the pattern generators and the LED pins. Drives a registered LED bus.

Parameters:
NREQ, 3, number of requesters (2..8)
LEDS, 5, LED bus width
LOG2TICK, 22, prescaler width; one tick every 2^LOG2TICK clk cycles
SLOT_TICKS, 4, ticks per grant slot (1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-source request; level, held while the source wants the LEDs
pat  input  NREQ*LEDS  flattened patterns; source i occupies bits [i*LEDS +: LEDS]
gnt  output  NREQ  one-hot grant, registered
led  output  LEDS  LED drive, registered
busy  output  1  high while any grant is active

Behaviour:
- Reset: the asynchronous assert of rst_n low forces the following. Deassert is sampled on the clk rising edge.
  - state=IDLE, gnt=0, led=0, busy=0.
  - Prescaler=0, slot count=0.
  - Round-robin pointer last=NREQ-1, so source 0 has first priority.
- Reset mid-slot: the grant is dropped immediately; no pattern persists.
- States: IDLE, GRANT.
- IDLE:
  - gnt=0, led=0, busy=0.
  - If req!=0 on a clk edge, choose winner w: the first set bit of req scanning last+1, last+2, … modulo NREQ.
  - Next cycle: state=GRANT, gnt=onehot(w), last=w, prescaler=0, slot count=0, busy=1.
- GRANT:
  - Each cycle, led <= pat[w] (live pattern, 1-cycle register latency).
  - Prescaler increments by 1, wrapping at 2^LOG2TICK. A tick occurs when the prescaler equals 2^LOG2TICK-1.
  - On a tick, slot count increments.
  - Slot end when both hold on the same edge: a tick, and slot count == SLOT_TICKS-1.
  - Full slot length is exactly SLOT_TICKS*2^LOG2TICK cycles of gnt high.
- Early release: if req[w]=0 on an edge in GRANT, the slot ends on that edge.
- At slot end: next state=IDLE for exactly one cycle, with gnt=0 and led=0 (visible blank gap). Arbitration then proceeds from IDLE as above.
  - The same source is re-granted only if no other source is requesting.
- Simultaneous events:
  - Early release and tick on the same edge: treat as a single slot end.
  - New requests arriving during GRANT wait; they never preempt.
- Fairness: with all sources requesting continuously, the grant order is 0,1,…,NREQ-1,0,… with no starvation.
- Width rules:
  - Prescaler is LOG2TICK bits; slot count is 8 bits.
  - pat bits for non-granted sources are ignored.
  - A req bit going high and low inside IDLE before the sampling edge is not remembered (level protocol).
- gnt is always one-hot or zero. busy == |gnt.

Test Plan (LOG2TICK=2, SLOT_TICKS=3, so slot = 12 cycles; NREQ=3, LEDS=5):
- Reset check: rst_n low mid-run -> gnt=000, led=00000, busy=0 without waiting for a clk edge. After release with req=000 -> all outputs stay 0.
- Single source: req=001, pat0=10101 held -> gnt=001 from cycle 1 for exactly 12 cycles; led=10101 from cycle 2. Then 1 gap cycle (gnt=0, led=0), then re-granted source 0.
- Round-robin: req=111, pat0=00001, pat1=00010, pat2=00100 -> grant order 0,1,2,0. Each slot is 12 cycles with a 1-cycle gap; led follows the granted pattern.
- Early release: grant to source 1, drop req[1] at slot cycle 5 -> gnt clears on the next edge, one gap cycle, then source 2 granted if req[2]=1.
- Live pattern: during a source 2 grant, change pat2 from 11111 to 00000 -> led updates exactly one cycle later.
- Priority rotation: after a source 2 slot with req=101 -> source 0 is granted next, not source 2.
